// File: rtl/mult_share_ctrl.sv
// Shares one combinational 16x16 multiplier between two requesters.
// Round-robin accept, fixed settle window, registered tagged response.
module boothwallace (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] P
);
  assign P = 32'(A) * 32'(B);
endmodule

module mult_share_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_p,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        id_q, id_d;
  logic        rid_q, rid_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_q, p_d;
  logic [31:0] prod;
  logic        gnt0, gnt1;
  logic        acc0, acc1;

  boothwallace u_mul (
    .A(a_q),
    .B(b_q),
    .P(prod)
  );

  // A lone requester wins regardless of priority.
  assign gnt0 = req0_valid & (~req1_valid | ~prio_q);
  assign gnt1 = req1_valid & (~req0_valid | prio_q);
  assign acc0 = rst_n & (state_q == S_IDLE) & gnt0;
  assign acc1 = rst_n & (state_q == S_IDLE) & gnt1;

  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign rsp_p      = p_q;
  assign rsp_id     = rid_q;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    rid_d   = rid_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc0 | acc1) begin
          a_d     = acc1 ? req1_a : req0_a;
          b_d     = acc1 ? req1_b : req0_b;
          id_d    = acc1;
          prio_d  = ~acc1;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          p_d     = prod;
          rid_d   = id_q;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      rid_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      rid_q   <= rid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: three instances with
// settle windows of 2, 1 and 15 cycles.
module tb_mult_share_ctrl;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    logic        id;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  v0 = '0;
  logic [2:0]  v1 = '0;
  logic [2:0]  rr = '1;
  logic [15:0] a0[3];
  logic [15:0] b0[3];
  logic [15:0] a1[3];
  logic [15:0] b1[3];
  wire  [2:0]  rdy0, rdy1, rv, rid, bsy;
  wire  [31:0] p[3];
  int errors = 0;
  int checks = 0;
  int oth;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mult_share_ctrl #(
      .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .req0_valid(v0[g]),
      .req0_ready(rdy0[g]),
      .req0_a(a0[g]),
      .req0_b(b0[g]),
      .req1_valid(v1[g]),
      .req1_ready(rdy1[g]),
      .req1_a(a1[g]),
      .req1_b(b1[g]),
      .rsp_valid(rv[g]),
      .rsp_ready(rr[g]),
      .rsp_id(rid[g]),
      .rsp_p(p[g]),
      .busy(bsy[g])
    );
  end

  function automatic int wc(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the port's ready, then take the accepting edge.
  task automatic wait_acc(int k, bit port, string nm);
    int n;
    n = 0;
    while ((port ? rdy1[k] : rdy0[k]) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_grant"}, 32'(n < 40), 32'd1);
    chk({nm, "_other_rdy"}, 32'(port ? rdy0[k] : rdy1[k]), 32'd0);
    tick();
  endtask

  // Called just after the accept edge; bp = cycles of rsp_ready low.
  task automatic finish_rsp(int k, logic [31:0] ep, logic eid,
                            string nm, int bp);
    int n;
    n = 0;
    oth = 0;
    rr[k] = (bp == 0);
    chk({nm, "_busy"}, 32'(bsy[k]), 32'd1);
    while (rv[k] !== 1'b1 && n < 40) begin
      if (rdy0[k] | rdy1[k]) oth = 1;
      tick();
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(wc(k)));
    chk({nm, "_p"}, p[k], ep);
    chk({nm, "_id"}, 32'(rid[k]), 32'(eid));
    for (int i = 0; i < bp; i++) begin
      if (rdy0[k] | rdy1[k]) oth = 1;
      tick();
      chk({nm, "_bp_valid"}, 32'(rv[k]), 32'd1);
      chk({nm, "_bp_p"}, p[k], ep);
      chk({nm, "_bp_id"}, 32'(rid[k]), 32'(eid));
    end
    if (rdy0[k] | rdy1[k]) oth = 1;
    chk({nm, "_rdy_quiet"}, 32'(oth), 32'd0);
    rr[k] = 1'b1;
    tick();
    chk({nm, "_done_valid"}, 32'(rv[k]), 32'd0);
    chk({nm, "_done_busy"}, 32'(bsy[k]), 32'd0);
  endtask

  vec_t dv[7];
  vec_t alt[6];
  vec_t sw[64];
  logic [15:0] ops[8];

  initial begin
    int seen;
    for (int k = 0; k < 3; k++) begin
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
    end
    dv[0] = '{16'hffff, 16'hffff, 32'hfffe0001, 1'b0};
    dv[1] = '{16'h7800, 16'h7da2, 32'h3ae3f000, 1'b1};
    dv[2] = '{16'h00ff, 16'h00ff, 32'h0000fe01, 1'b0};
    dv[3] = '{16'h8c1b, 16'h92a3, 32'h50409b31, 1'b1};
    dv[4] = '{16'h0001, 16'h0000, 32'h00000000, 1'b0};
    dv[5] = '{16'hffff, 16'h0001, 32'h0000ffff, 1'b1};
    dv[6] = '{16'h00ff, 16'h0100, 32'h0000ff00, 1'b0};
    alt[0] = '{16'h0001, 16'hffff, 32'h0000ffff, 1'b0};
    alt[1] = '{16'hffff, 16'h00ff, 32'h00feff01, 1'b1};
    alt[2] = '{16'h7800, 16'h0002, 32'h0000f000, 1'b0};
    alt[3] = '{16'h8c1b, 16'h0001, 32'h00008c1b, 1'b1};
    alt[4] = '{16'h00ff, 16'h0100, 32'h0000ff00, 1'b0};
    alt[5] = '{16'h92a3, 16'h0010, 32'h00092a30, 1'b1};
    ops = '{16'h0001, 16'h0000, 16'hffff, 16'h00ff,
            16'h7800, 16'h8c1b, 16'h92a3, 16'h7da2};
    for (int i = 0; i < 64; i++) begin
      sw[i].a  = ops[i / 8];
      sw[i].b  = ops[i % 8];
      sw[i].p  = 32'(sw[i].a) * 32'(sw[i].b);
      sw[i].id = 1'(i % 2);
    end

    // Reset state, with a request pending on port 0.
    v0[0] = 1'b1;
    tick();
    chk("rst_rdy0", 32'(rdy0[0]), 32'd0);
    chk("rst_valid", 32'(rv[0]), 32'd0);
    chk("rst_p", p[0], 32'd0);
    chk("rst_id", 32'(rid[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    v0[0] = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single-port directed table.
    for (int i = 0; i < 7; i++) begin
      if (dv[i].id) begin
        a1[0] = dv[i].a; b1[0] = dv[i].b; v1[0] = 1'b1;
      end else begin
        a0[0] = dv[i].a; b0[0] = dv[i].b; v0[0] = 1'b1;
      end
      wait_acc(0, dv[i].id, $sformatf("dv%0d", i));
      v0[0] = 1'b0;
      v1[0] = 1'b0;
      finish_rsp(0, dv[i].p, dv[i].id, $sformatf("dv%0d", i), 0);
    end

    // Simultaneous requests straight after reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    a0[0] = 16'h7800; b0[0] = 16'h7da2;
    a1[0] = 16'h00ff; b1[0] = 16'h00ff;
    v0[0] = 1'b1; v1[0] = 1'b1;
    wait_acc(0, 1'b0, "both0");
    v0[0] = 1'b0;
    finish_rsp(0, 32'h3ae3f000, 1'b0, "both0", 0);
    wait_acc(0, 1'b1, "both1");
    v1[0] = 1'b0;
    finish_rsp(0, 32'h0000fe01, 1'b1, "both1", 0);

    // Both ports held valid: grants alternate.
    a0[0] = alt[0].a; b0[0] = alt[0].b;
    a1[0] = alt[1].a; b1[0] = alt[1].b;
    v0[0] = 1'b1; v1[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_acc(0, alt[i].id, $sformatf("alt%0d", i));
      if (i + 2 < 6) begin
        if (alt[i].id) begin
          a1[0] = alt[i + 2].a; b1[0] = alt[i + 2].b;
        end else begin
          a0[0] = alt[i + 2].a; b0[0] = alt[i + 2].b;
        end
      end
      finish_rsp(0, alt[i].p, alt[i].id, $sformatf("alt%0d", i), 0);
    end
    v0[0] = 1'b0; v1[0] = 1'b0;

    // Backpressure with a second request waiting.
    a0[0] = 16'h8c1b; b0[0] = 16'h92a3; v0[0] = 1'b1;
    wait_acc(0, 1'b0, "bp");
    v0[0] = 1'b0;
    a1[0] = 16'h0001; b1[0] = 16'h0001; v1[0] = 1'b1;
    finish_rsp(0, 32'h50409b31, 1'b0, "bp", 5);
    chk("bp_next_rdy", 32'(rdy1[0]), 32'd1);
    tick();
    chk("bp_next_busy", 32'(bsy[0]), 32'd1);
    v1[0] = 1'b0;
    finish_rsp(0, 32'h00000001, 1'b1, "bp_next", 0);

    // Reset pulse while an op is in WAIT.
    a0[0] = 16'h1234; b0[0] = 16'h5678; v0[0] = 1'b1;
    wait_acc(0, 1'b0, "rw");
    v0[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    chk("rw_busy_in_rst", 32'(bsy[0]), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rv[0] | bsy[0]) seen = 1;
    end
    chk("rw_no_rsp", 32'(seen), 32'd0);
    a0[0] = 16'h0001; b0[0] = 16'h0000;
    a1[0] = 16'h0001; b1[0] = 16'h0000;
    v0[0] = 1'b1; v1[0] = 1'b1;
    wait_acc(0, 1'b0, "rw_after");
    v0[0] = 1'b0; v1[0] = 1'b0;
    finish_rsp(0, 32'h00000000, 1'b0, "rw_after", 0);

    // Operand sweep at the settle-window extremes.
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 64; i++) begin
        if (sw[i].id) begin
          a1[k] = sw[i].a; b1[k] = sw[i].b; v1[k] = 1'b1;
        end else begin
          a0[k] = sw[i].a; b0[k] = sw[i].b; v0[k] = 1'b1;
        end
        wait_acc(k, sw[i].id, $sformatf("sw%0d_%0d", k, i));
        v0[k] = 1'b0;
        v1[k] = 1'b0;
        finish_rsp(k, sw[i].p, sw[i].id, $sformatf("sw%0d_%0d", k, i), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
